keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Scans a 4x4 matrix keypad (drive one column low, read the rows) and debounces the result.
//   Reports each new key press as a single-cycle strobe with a 4-bit key code.
//   Shifts decimal key presses into a 4-digit entry buffer whose outputs feed the display driver digits.
//   Sits between the board keypad pins and the application/display logic; this is the input side of the multiplexed panel.
// PARAMETERS
//   SCAN_TICKS      100_000  clk cycles each column is driven (1 ms at 100 MHz); >= 4
//   DEBOUNCE_SCANS  20       consecutive identical full scans needed to accept a change; >= 2
// PORTS
//   clk        in   1  system clock
//   reset      in   1  synchronous, active-high reset
//   row        in   4  keypad rows, active-low (pulled up), asynchronous; row[0] = top row
//   col        out  4  keypad columns, active-low, exactly one low at any time; col[0] = left column
//   key_code   out  4  code of the last accepted key; held until the next accepted key
//   key_valid  out  1  one-cycle strobe when a new key is accepted
//   key_held   out  1  high while the accepted key remains debounced-pressed
//   digit3..0  out  4  each; entry buffer, digit3 = oldest/leftmost, values 0-9
// BEHAVIOUR
//   Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0, digit3..0=0; all counters 0; state RELEASED.
//   Sync: row passes through a 2-flop synchronizer before any use.
//   Column walk: a dwell counter of width $clog2(SCAN_TICKS) counts 0..SCAN_TICKS-1.
//     On terminal count, the column advances 1110->1101->1011->0111->1110.
//     Scan period = 4*SCAN_TICKS cycles.
//   Sample: the synchronized row is captured on the terminal-count cycle of each column dwell (before col changes).
//     The capture is ORed into a per-scan record.
//   Scan result: evaluated on the col[3] terminal count. It is one of:
//     NONE  - no row low in any column
//     KEY(k) - exactly one row/col intersection low
//     MULTI - two or more intersections low
//   After evaluation, the per-scan record clears.
//   Keymap (row,col -> code):
//     r0: 1 2 3 A
//     r1: 4 5 6 B
//     r2: 7 8 9 C
//     r3: *=E 0 #=F D
//   Debounce: if result == previous result, match_cnt increments (saturating at DEBOUNCE_SCANS).
//     Otherwise the previous result is replaced and match_cnt = 1.
//     A result is accepted on the scan where match_cnt reaches DEBOUNCE_SCANS.
//   FSM (on accepted results only):
//     RELEASED + KEY(k)        -> PRESSED: key_code=k, key_valid=1 for one cycle, key_held=1
//     PRESSED  + NONE/MULTI    -> RELEASED: key_held=0, no strobe
//     PRESSED  + KEY(j), j!=k  -> PRESSED: treated as release+press; key_code=j, strobe once
//     RELEASED + MULTI         -> stays RELEASED; no strobe (ghost/rollover rejected)
//     same KEY re-accepted     -> no action
//   Latency: a clean press is strobed on the evaluation cycle of the DEBOUNCE_SCANS-th full scan containing it,
//     plus 1 cycle (registered outputs).
//   Entry buffer: updated in the same cycle key_valid is asserted.
//     code 0-9: digit3<=digit2, digit2<=digit1, digit1<=digit0, digit0<=code
//     code E (*): all digits <= 0
//     all other codes: buffer unchanged
//   Reset mid-operation: reset overrides everything. A key still held after reset is re-reported after a full debounce.
// STRUCTURE
//   keypad_pkg:
//     localparam key codes KEY_STAR=4'hE, KEY_HASH=4'hF
//     result-kind enum {RES_NONE, RES_KEY, RES_MULTI}
//     function keymap(row_idx, col_idx) -> [3:0]
//   Sub-module keypad_debounce: compares scan results and owns match_cnt, previous result and the accepted-result
//     output pulse. Column walk, FSM and entry buffer remain in keypad_scanner.
// TESTING (bench uses SCAN_TICKS=4, DEBOUNCE_SCANS=3; scan period 16 cycles)
//   1. After reset, idle -> col cycles 1110,1101,1011,0111 with 4 cycles each; key_valid never asserts.
//   2. Hold '5' (row[1] low while col[1] low) -> exactly one key_valid, key_code=5, key_held=1, digits=0,0,0,5;
//      release -> key_held=0 after 3 scans.
//   3. Toggle '5' every scan for 2 scans, then hold steady -> exactly one key_valid total.
//   4. Press '1' and '2' together -> no key_valid, key_held=0; then release '2' -> one strobe, code 1.
//   5. Enter 1,2,3,4,7 with releases between -> digit3..0 = 2,3,4,7;
//      then '*' -> key_valid with code E, digits all 0; then 'A' -> code A, digits unchanged.
//   6. Hold '9', assert reset mid-scan for 1 cycle -> all outputs return to reset values;
//      '9' strobed again after 3 scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and the key map for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } res_kind_e;

  // One full-scan result; code is forced to 0 unless kind is RES_KEY so
  // that whole-struct equality is the debounce comparison.
  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] code;
  } scan_res_t;

  typedef enum logic {
    ST_RELEASED,
    ST_PRESSED
  } key_state_e;

  function automatic logic [3:0] keymap(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-result debouncer: a result is accepted on the scan where it has been
// seen DEBOUNCE_SCANS times in a row. The accept pulse is combinational on
// the evaluation cycle so the scanner can register it once.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      eval_i,
  input  scan_res_t res_i,
  output logic      acc_o,
  output scan_res_t acc_res_o
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_SCANS);

  scan_res_t     prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Compare against the previous result, count matches, pulse on reaching the limit.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    acc_o  = 1'b0;
    if (eval_i) begin
      if (res_i == prev_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
          acc_o = (cnt_d == CNT_MAX);
        end
      end else begin
        prev_d = res_i;
        cnt_d  = CW'(1);
      end
    end
  end

  assign acc_res_o = res_i;

  // Previous-result and match-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= '{kind: RES_NONE, code: 4'h0};
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column walk, per-scan row capture, debounce, press FSM
// and a 4-digit decimal entry buffer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_TICKS     = 100_000,
  parameter int unsigned DEBOUNCE_SCANS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0
);

  localparam int unsigned   DW         = $clog2(SCAN_TICKS);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_TICKS - 1);

  logic [3:0]       row_s1_q, row_s2_q;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [15:0]      rec_q, rec_d, rec_full;
  logic             tc, eval;
  logic [4:0]       hits;
  logic [1:0]       hit_r, hit_c;
  scan_res_t        res, acc_res;
  logic             acc;
  key_state_e       state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [3:0][3:0]  dig_q, dig_d;

  assign tc   = (dwell_q == DWELL_LAST);
  assign eval = tc && (col_idx_q == 2'd3);

  // Column walk and per-scan record; record bit {row,col} is set when that
  // intersection read low. The evaluated scan includes the current capture.
  always_comb begin
    dwell_d   = dwell_q + 1'b1;
    col_idx_d = col_idx_q;
    col_d     = col_q;
    rec_full  = rec_q;
    rec_d     = rec_q;
    if (tc) begin
      dwell_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = {col_q[2:0], col_q[3]};
      for (int unsigned r = 0; r < 4; r++) begin
        if (!row_s2_q[r]) rec_full[{r[1:0], col_idx_q}] = 1'b1;
      end
      rec_d = eval ? '0 : rec_full;
    end
  end

  // Classify the completed scan as NONE, a single key, or MULTI.
  always_comb begin
    hits  = 5'd0;
    hit_r = 2'd0;
    hit_c = 2'd0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (rec_full[i]) begin
        hits  = hits + 5'd1;
        hit_r = i[3:2];
        hit_c = i[1:0];
      end
    end
    if (hits == 5'd0)      res = '{kind: RES_NONE,  code: 4'h0};
    else if (hits == 5'd1) res = '{kind: RES_KEY,   code: keymap(hit_r, hit_c)};
    else                   res = '{kind: RES_MULTI, code: 4'h0};
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk       (clk),
    .reset     (reset),
    .eval_i    (eval),
    .res_i     (res),
    .acc_o     (acc),
    .acc_res_o (acc_res)
  );

  // Press FSM and entry buffer, acting only on accepted results.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    dig_d   = dig_q;
    if (acc && acc_res.kind == RES_KEY &&
        (state_q == ST_RELEASED || acc_res.code != code_q)) begin
      state_d = ST_PRESSED;
      code_d  = acc_res.code;
      valid_d = 1'b1;
      if (acc_res.code <= 4'd9)          dig_d = {dig_q[2:0], acc_res.code};
      else if (acc_res.code == KEY_STAR) dig_d = '0;
    end else if (acc && acc_res.kind != RES_KEY) begin
      state_d = ST_RELEASED;
    end
  end

  // All state registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q  <= '1;
      row_s2_q  <= '1;
      dwell_q   <= '0;
      col_idx_q <= '0;
      col_q     <= 4'b1110;
      rec_q     <= '0;
      state_q   <= ST_RELEASED;
      code_q    <= '0;
      valid_q   <= 1'b0;
      dig_q     <= '0;
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      rec_q     <= rec_d;
      state_q   <= state_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      dig_q     <= dig_d;
    end
  end

  assign col       = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == ST_PRESSED);
  assign digit3    = dig_q[3];
  assign digit2    = dig_q[2];
  assign digit1    = dig_q[1];
  assign digit0    = dig_q[0];

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad board model drives rows
// from the pressed-key set, and a scan-level reference model predicts outputs.
module tb_keypad_scanner;

  localparam int unsigned ST = 4;
  localparam int unsigned DS = 3;
  localparam int unsigned SCAN = 4 * ST;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row, col, key_code, digit3, digit2, digit1, digit0;
  logic       key_valid, key_held;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c pressed

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;

  // Reference model state
  int unsigned kmap [16] = '{1, 2, 3, 'hA, 4, 5, 6, 'hB, 7, 8, 9, 'hC, 'hE, 0, 'hF, 'hD};
  int          m_prev_kind, m_prev_code, m_cnt;
  bit          m_held;
  int unsigned m_code;
  int unsigned m_dig [4];   // m_dig[3] = oldest
  bit          m_valid;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held),
    .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0)
  );

  always #5 clk = ~clk;

  // Board: a row reads low when a pressed key in it sits on the driven-low column.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] kb(input int r, input int c);
    return 16'(1) << (r * 4 + c);
  endfunction

  function automatic logic [15:0] exp_digits();
    return 16'((m_dig[3] << 12) | (m_dig[2] << 8) | (m_dig[1] << 4) | m_dig[0]);
  endfunction

  task automatic model_reset();
    m_prev_kind = 0; m_prev_code = 0; m_cnt = 0;
    m_held = 0; m_code = 0; m_valid = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
  endtask

  // Scan-level model: classify the set of pressed keys, debounce, act on acceptance.
  task automatic model_scan(input logic [15:0] k);
    int kind, code, n;
    bit same;
    n = $countones(k);
    kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    code = 0;
    for (int i = 0; i < 16; i++) if (n == 1 && k[i]) code = int'(kmap[i]);
    same = (kind == m_prev_kind) && (kind != 1 || code == m_prev_code);
    if (!same) begin
      m_prev_kind = kind; m_prev_code = code; m_cnt = 1;
    end else if (m_cnt < int'(DS)) begin
      m_cnt++;
      if (m_cnt == int'(DS)) begin
        if (kind == 1 && (!m_held || int'(m_code) != code)) begin
          m_held = 1; m_code = code; m_valid = 1;
          if (code <= 9) begin
            m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0];
            m_dig[0] = code;
          end else if (code == 'hE) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
          end
        end else if (kind != 1) begin
          m_held = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input logic [3:0] ecol);
    check_eq("col", col, ecol);
    check_eq("key_valid", key_valid, m_valid);
    check_eq("key_code", key_code, m_code);
    check_eq("key_held", key_held, m_held);
    check_eq("digits", {digit3, digit2, digit1, digit0}, exp_digits());
  endtask

  // Hold the key set for ncyc cycles of a scan aligned to column 0.
  task automatic scan(input logic [15:0] k, input int ncyc = SCAN);
    logic [3:0] ecol;
    keys = k;
    for (int j = 1; j <= ncyc; j++) begin
      @(posedge clk); #1;
      m_valid = 0;
      if (j == int'(SCAN)) model_scan(k);
      ecol = ~(4'(1) << ((j / int'(ST)) % 4));
      check_outputs(ecol);
      if (key_valid) n_strobes++;
    end
  endtask

  task automatic scans(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) scan(k);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    check_outputs(4'b1110);
  endtask

  initial begin
    int s0;
    logic [15:0] k;
    model_reset();
    do_reset();

    // 1: idle walk, no strobes
    scans('0, 4);
    check_eq("idle_strobes", n_strobes, 0);

    // 2: hold '5', then release
    s0 = n_strobes;
    scans(kb(1, 1), 4);
    check_eq("t2_strobes", n_strobes - s0, 1);
    check_eq("t2_code", key_code, 4'h5);
    check_eq("t2_held", key_held, 1'b1);
    check_eq("t2_digits", {digit3, digit2, digit1, digit0}, 16'h0005);
    scans('0, 4);
    check_eq("t2_released", key_held, 1'b0);

    // 3: bouncing '5' then steady
    s0 = n_strobes;
    scan(kb(1, 1)); scan('0);
    scans(kb(1, 1), 4);
    scans('0, 4);
    check_eq("t3_strobes", n_strobes - s0, 1);

    // 4: '1'+'2' rejected, then '1' alone accepted
    s0 = n_strobes;
    scans(kb(0, 0) | kb(0, 1), 4);
    check_eq("t4_multi_strobes", n_strobes - s0, 0);
    check_eq("t4_multi_held", key_held, 1'b0);
    scans(kb(0, 0), 4);
    check_eq("t4_strobes", n_strobes - s0, 1);
    check_eq("t4_code", key_code, 4'h1);
    scans('0, 4);

    // 5: entry buffer shifting, clear and non-digit keys
    foreach (k[i]) ;
    scans(kb(0, 0), 3); scans('0, 3);
    scans(kb(0, 1), 3); scans('0, 3);
    scans(kb(0, 2), 3); scans('0, 3);
    scans(kb(1, 0), 3); scans('0, 3);
    scans(kb(2, 0), 3); scans('0, 3);
    check_eq("t5_digits", {digit3, digit2, digit1, digit0}, 16'h2347);
    scans(kb(3, 0), 3);
    check_eq("t5_star_code", key_code, 4'hE);
    check_eq("t5_star_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    scans('0, 3);
    scans(kb(0, 3), 3);
    check_eq("t5_a_code", key_code, 4'hA);
    check_eq("t5_a_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    scans('0, 4);

    // 6: reset mid-scan while '9' held, re-reported after a full debounce
    scans(kb(2, 2), 4);
    check_eq("t6_code", key_code, 4'h9);
    scan(kb(2, 2), 7);
    do_reset();
    s0 = n_strobes;
    scans(kb(2, 2), 4);
    check_eq("t6_restrobe", n_strobes - s0, 1);
    check_eq("t6_recode", key_code, 4'h9);
    scans('0, 4);

    // Random key sets held for random numbers of scans
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       k = '0;
        1, 2:    k = kb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        default: k = kb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))) |
                     kb(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      endcase
      scans(k, int'($urandom_range(1, 5)));
    end
    scans('0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
